// File: rtl/pb_debounce_pkg.sv
// pb_debounce_pkg: shared FSM state type and default timing constants for the pushbutton conditioner.
package pb_debounce_pkg;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } pb_state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;
endpackage

// File: rtl/pb_debounce_sync.sv
// sync_ff: STAGES-deep reset-clearable synchroniser for a single asynchronous bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= '0;
        else        r <= {r[STAGES-2:0], d};
    end
    assign q = r[STAGES-1];
endmodule

// File: rtl/pb_debounce_pulse.sv
// pb_debounce_pulse: synchronise, debounce and strobe a raw pushbutton.
// Optional auto-repeat of press_pulse while held is enabled by defining PB_AUTOREPEAT_EN.
module pb_debounce_pulse
    import pb_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    pb_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic sync_q, press_n, press_d, release_n, level_n;
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_in),
        .q    (sync_q)
    );
`ifdef PB_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] RPT_DLY_M1 = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PER_M1 = RW'(REPEAT_PERIOD - 1);
    logic [RW-1:0] rpt, rpt_n;
    logic rpt_first, rpt_first_n, rpt_fire;
`endif
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            IDLE: begin
                state_n = sync_q ? PRESS_WAIT : IDLE;
                cnt_n   = sync_q ? CW'(1) : '0;
            end
            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                state_n = sync_q ? PRESSED : RELEASE_WAIT;
                cnt_n   = sync_q ? cnt : CW'(1);
            end
            RELEASE_WAIT: begin
                if (sync_q) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        level_n = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
`ifdef PB_AUTOREPEAT_EN
        // Repeat counter measures cycles since the last press strobe; it only advances while PRESSED.
        rpt_n       = rpt;
        rpt_first_n = rpt_first;
        rpt_fire    = 1'b0;
        if (press_n || state_n == IDLE) begin
            rpt_n       = '0;
            rpt_first_n = 1'b1;
        end else if (state == PRESSED && state_n == PRESSED) begin
            if (rpt >= (rpt_first ? RPT_DLY_M1 : RPT_PER_M1)) begin
                rpt_fire    = 1'b1;
                rpt_n       = '0;
                rpt_first_n = 1'b0;
            end else begin
                rpt_n = rpt + 1'b1;
            end
        end
        press_d = press_n | rpt_fire;
`else
        press_d = press_n;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            btn_level     <= level_n;
            press_pulse   <= press_d;
            release_pulse <= release_n;
        end
    end
`ifdef PB_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt       <= '0;
            rpt_first <= 1'b1;
        end else begin
            rpt       <= rpt_n;
            rpt_first <= rpt_first_n;
        end
    end
`endif
endmodule

// File: tb/tb_pb_debounce_pulse.sv
// tb_pb_debounce_pulse: scoreboard bench for pb_debounce_pulse with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_pb_debounce_pulse;
    localparam int LAT = 6;
    typedef struct {
        bit press;
        int cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level, press_pulse, release_pulse;
    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    exp_t q[$];
    pb_debounce_pulse #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic expect_pulse(input bit press, input int at);
        exp_t x;
        x.press = press;
        x.cyc   = at;
        q.push_back(x);
    endtask
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask
    always @(negedge clk) begin
        exp_t x;
        if (press_pulse || release_pulse) begin
            check("pulse_exclusive", int'(press_pulse && release_pulse), 0);
            if (q.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, -1);
            end else begin
                x = q.pop_front();
                check(x.press ? "press_cycle" : "release_cycle", cyc, x.cyc);
                check("pulse_kind", int'(press_pulse), int'(x.press));
                check("pulse_level", int'(btn_level), int'(x.press));
            end
        end
    end
    initial begin
        int e, a;
        repeat (3) @(negedge clk);
        check("rst_level", int'(btn_level), 0);
        check("rst_press", int'(press_pulse), 0);
        check("rst_release", int'(release_pulse), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // Clean press held 30 cycles past accept, then clean release.
        btn_in = 1'b1;
        e = cyc + 1;
        a = e + LAT;
        expect_pulse(1'b1, a);
`ifdef PB_AUTOREPEAT_EN
        for (int k = 10; k <= 30; k += 5) expect_pulse(1'b1, a + k);
`endif
        wait_until(a + 30);
        btn_in = 1'b0;
        e = cyc + 1;
        expect_pulse(1'b0, e + LAT);
        wait_until(e + LAT + 3);
        // Bounce 1,0,1,0 then held high.
        for (int i = 0; i < 4; i++) begin
            btn_in = (i % 2 == 0);
            @(negedge clk);
            check("bounce_level", int'(btn_level), 0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bounce_settle_level", int'(btn_level), 0);
        end
        btn_in = 1'b1;
        e = cyc + 1;
        a = e + LAT;
        expect_pulse(1'b1, a);
        wait_until(a + 2);
        // Short low dip from PRESSED must not release.
        btn_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dip_low_level", int'(btn_level), 1);
        end
        btn_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dip_high_level", int'(btn_level), 1);
        end
        btn_in = 1'b0;
        e = cyc + 1;
        expect_pulse(1'b0, e + LAT);
        wait_until(e + LAT + 3);
        // Reset while counting in PRESS_WAIT (cnt=3), button still held.
        btn_in = 1'b1;
        e = cyc + 1;
        wait_until(e + 4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pw_level", int'(btn_level), 0);
        check("rst_pw_press", int'(press_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        e = cyc + 1;
        a = e + LAT;
        expect_pulse(1'b1, a);
        wait_until(a + 2);
        // Reset while PRESSED: level drops at once, press re-qualified.
        #2 rst_n = 1'b0;
        #1;
        check("rst_pressed_level", int'(btn_level), 0);
        check("rst_pressed_release", int'(release_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        e = cyc + 1;
        a = e + LAT;
        expect_pulse(1'b1, a);
        wait_until(a + 2);
        btn_in = 1'b0;
        e = cyc + 1;
        expect_pulse(1'b0, e + LAT);
        wait_until(e + LAT + 10);
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pb_debounce_pulse.md
Name: pb_debounce_pulse

Overview:
- Conditions a raw, bouncing, asynchronous pushbutton for the non-sequential 4-bit counter stage directly downstream.
- Synchronises the button to clk, debounces it with a stable-time counter, and emits a clean debounced level.
- Produces one-cycle press and release strobes; press_pulse is the counter's advance input.

Parameters:
- SYNC_STAGES, 2: synchroniser flop count; must be >= 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a change (10 ms at 100 MHz); must be >= 1.
- REPEAT_DELAY, 50000000: cycles from the first press_pulse to the first auto-repeat pulse (used only with the macro).
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses (used only with the macro).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  1  raw pushbutton, asynchronous to clk, active-high.
- btn_level  out  1  debounced level; 1 in PRESSED and RELEASE_WAIT.
- press_pulse  out  1  one-cycle strobe on an accepted press (and on auto-repeat).
- release_pulse  out  1  one-cycle strobe on an accepted release.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All outputs are registered.
- Reset (rst_n=0, immediate, independent of clk):
  - synchroniser flops, debounce counter, repeat counter, btn_level, press_pulse and release_pulse all = 0; state = IDLE.
- Release of reset takes effect on the first clk edge with rst_n=1.
- Synchroniser: SYNC_STAGES-deep flop chain; its last stage is sync_q. The FSM sees only sync_q, never btn_in.
- Debounce counter: width = clog2(DEBOUNCE_CYCLES+1) (localparam); it saturates and never wraps.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: sync_q=1 -> PRESS_WAIT, cnt=1; otherwise stay, cnt=0.
  - PRESS_WAIT:
    - sync_q=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
    - sync_q=1 and cnt==DEBOUNCE_CYCLES -> PRESSED, cnt=0, press_pulse=1 for exactly one cycle.
    - otherwise cnt+1.
  - PRESSED: sync_q=0 -> RELEASE_WAIT, cnt=1; otherwise stay.
  - RELEASE_WAIT:
    - sync_q=1 -> PRESSED, cnt=0 (no pulse).
    - sync_q=0 and cnt==DEBOUNCE_CYCLES -> IDLE, cnt=0, release_pulse=1 for one cycle.
    - otherwise cnt+1.
- Latency: with btn_in held high, press_pulse goes high SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples btn_in=1. Release latency is symmetric.
- Pulses:
  - press_pulse and release_pulse are never both high in the same cycle.
  - Each is high for exactly one cycle per accepted event.
  - btn_level changes in the same cycle as the corresponding pulse.
- Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES+1 synchronised cycles produces no pulse and no btn_level change.
- Reset mid-debounce: any partial count is discarded, the FSM returns to IDLE, and no pulse is emitted. A button still held after reset must be fully re-qualified (one press_pulse after full latency).
- Unreachable state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter runs. press_pulse is reasserted for one cycle REPEAT_DELAY cycles after the accepting press_pulse, then every REPEAT_PERIOD cycles while PRESSED.
  - The repeat counter freezes in RELEASE_WAIT and resumes if the FSM returns to PRESSED.
  - The repeat counter clears on entry to IDLE and on reset.
- Undefined: no repeat counter is synthesised; exactly one press_pulse per accepted press.

Decomposition:
- Package pb_debounce_pkg:
  - state typedef enum (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3);
  - default DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD constants.
- Sub-module sync_ff: SYNC_STAGES-parameterised synchroniser with rst_n; instantiated once.
- FSM, counters and pulse registers stay in pb_debounce_pulse.

Test Plan:
- SYNC_STAGES=2, DEBOUNCE_CYCLES=4; btn_in 0->1 held -> press_pulse high for exactly 1 cycle, 6 edges after first high sample; btn_level=1 from that cycle.
- Bounce 1,0,1,0 (one cycle each) then held 1 -> no pulse during bounce; exactly one press_pulse after stable; btn_level never toggles during bounce.
- From PRESSED, btn_in low 3 cycles then high again -> no release_pulse; state returns to PRESSED; btn_level stays 1.
- Held then released -> release_pulse one cycle, 6 edges after first low sample; btn_level=0; press_pulse=0 throughout release.
- rst_n pulsed low while cnt=3 in PRESS_WAIT, btn_in still high -> outputs 0 immediately; press_pulse occurs 6 edges after reset deassertion, not earlier.
- PB_AUTOREPEAT_EN defined, REPEAT_DELAY=10, REPEAT_PERIOD=5, button held 30 cycles past accept -> press_pulse at accept, +10, +15, +20, +25, +30.
